// File: rtl/dvi_timing_ctrl_pkg.sv
// Shared definitions for the DVI raster timing controller: the four-phase
// timing state encoding used by both axes, and the blanking constants.
package dvi_timing_ctrl_pkg;

    // Timing phase of one axis; both axes step through the same order.
    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FRONT  = 2'd1;
    localparam logic [1:0] ST_SYNC   = 2'd2;
    localparam logic [1:0] ST_BACK   = 2'd3;

    // Pixel value driven to the encoders outside active video or on underflow.
    localparam logic [23:0] BLANK_RGB = 24'h00_00_00;

    // Control symbols for the green/red encoders are never used.
    localparam logic [1:0] BLANK_CTL = 2'b00;

    // Phases wrap BACK -> ACTIVE, which the 2-bit encoding gives for free.
    function automatic logic [1:0] next_phase(input logic [1:0] s);
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/dvi_timing_axis.sv
// One raster axis (horizontal or vertical): a four-phase FSM with a
// down-counter that is reloaded with (length-1) each time a phase is entered.
module dvi_timing_axis
    import dvi_timing_ctrl_pkg::*;
#(
    parameter int W_CTR = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             advance,
    input  logic [W_CTR-1:0] len_active_m1,
    input  logic [W_CTR-1:0] len_front_m1,
    input  logic [W_CTR-1:0] len_sync_m1,
    input  logic [W_CTR-1:0] len_back_m1,
    output logic [1:0]       state,
    output logic             last
);

    logic [W_CTR-1:0] ctr;
    logic [1:0]       nxt;
    logic [W_CTR-1:0] reload;

    // Reload value for the phase that follows the current one.
    always_comb begin
        nxt    = next_phase(state);
        reload = len_active_m1;
        case (nxt)
            ST_ACTIVE: reload = len_active_m1;
            ST_FRONT:  reload = len_front_m1;
            ST_SYNC:   reload = len_sync_m1;
            ST_BACK:   reload = len_back_m1;
            default:   reload = len_active_m1;
        endcase
    end

    // Phase/counter update; hold parks the axis at the start of ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACTIVE;
            ctr   <= len_active_m1;
        end else if (hold) begin
            state <= ST_ACTIVE;
            ctr   <= len_active_m1;
        end else if (advance) begin
            if (ctr == '0) begin
                state <= nxt;
                ctr   <= reload;
            end else begin
                ctr <= ctr - 1'b1;
            end
        end
    end

    assign last = (state == ST_BACK) && (ctr == '0);

endmodule

// File: rtl/dvi_timing_ctrl.sv
// DVI raster timing controller: drives the three TMDS encoders with sync,
// data-enable and pixel data, pulling pixels from scanout over ready/valid.
module dvi_timing_ctrl
    import dvi_timing_ctrl_pkg::*;
#(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   W_CTR     = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] rgb,
    input  logic        rgb_valid,
    output logic        rgb_ready,
    input  logic        underflow_clr,
    output logic        underflow,
    output logic        sof,
    output logic        den,
    output logic [1:0]  c0,
    output logic [1:0]  c1,
    output logic [1:0]  c2,
    output logic [7:0]  d0,
    output logic [7:0]  d1,
    output logic [7:0]  d2
);

    localparam logic [W_CTR-1:0] H_ACT_M1 = W_CTR'(H_ACTIVE - 1);
    localparam logic [W_CTR-1:0] H_FP_M1  = W_CTR'(H_FRONT - 1);
    localparam logic [W_CTR-1:0] H_SY_M1  = W_CTR'(H_SYNC - 1);
    localparam logic [W_CTR-1:0] H_BP_M1  = W_CTR'(H_BACK - 1);
    localparam logic [W_CTR-1:0] V_ACT_M1 = W_CTR'(V_ACTIVE - 1);
    localparam logic [W_CTR-1:0] V_FP_M1  = W_CTR'(V_FRONT - 1);
    localparam logic [W_CTR-1:0] V_SY_M1  = W_CTR'(V_SYNC - 1);
    localparam logic [W_CTR-1:0] V_BP_M1  = W_CTR'(V_BACK - 1);

    logic [1:0] h_state, v_state;
    logic       h_last, v_last;
    logic       hsync, vsync;
    logic       at_origin;

    // Horizontal axis free-runs every cycle while enabled.
    dvi_timing_axis #(.W_CTR(W_CTR)) u_h_axis (
        .clk           (clk),
        .rst_n         (rst_n),
        .hold          (!en),
        .advance       (1'b1),
        .len_active_m1 (H_ACT_M1),
        .len_front_m1  (H_FP_M1),
        .len_sync_m1   (H_SY_M1),
        .len_back_m1   (H_BP_M1),
        .state         (h_state),
        .last          (h_last)
    );

    // Vertical axis steps once per line, on the last back-porch cycle.
    dvi_timing_axis #(.W_CTR(W_CTR)) u_v_axis (
        .clk           (clk),
        .rst_n         (rst_n),
        .hold          (!en),
        .advance       (h_last),
        .len_active_m1 (V_ACT_M1),
        .len_front_m1  (V_FP_M1),
        .len_sync_m1   (V_SY_M1),
        .len_back_m1   (V_BP_M1),
        .state         (v_state),
        .last          (v_last)
    );

    // Pixel slot and sync levels for the current timing state.
    always_comb begin
        rgb_ready = en && (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
        hsync     = (en && h_state == ST_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync     = (en && v_state == ST_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    end

    // Marks that the timing state is at pixel (0,0): after a hold or right
    // after the last cycle of a frame. Avoids exposing the axis counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   at_origin <= 1'b1;
        else if (!en) at_origin <= 1'b1;
        else          at_origin <= h_last && v_last;
    end

    // Encoder input registers, one cycle behind the timing state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            den          <= 1'b0;
            {d2, d1, d0} <= BLANK_RGB;
            c0           <= {~VSYNC_POL, ~HSYNC_POL};
            sof          <= 1'b0;
        end else begin
            den          <= rgb_ready;
            {d2, d1, d0} <= (rgb_ready && rgb_valid) ? rgb : BLANK_RGB;
            c0           <= {vsync, hsync};
            sof          <= rgb_ready && at_origin;
        end
    end

    // Sticky underflow; a new miss wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        underflow <= 1'b0;
        else if (rgb_ready && !rgb_valid)  underflow <= 1'b1;
        else if (underflow_clr)            underflow <= 1'b0;
    end

    assign c1 = BLANK_CTL;
    assign c2 = BLANK_CTL;

endmodule
